fifo_lvl: RTL and testbench
===========================

// Module: fifo_lvl
// PURPOSE
//  Single-clock, parametrised FIFO: next generation of the chip-level FIFO primitive.
//  Adds any depth >= 2 (not only powers of two) and a live fill-level output.
//  Adds programmable almost-full/empty thresholds, sticky overflow/underflow flags,
//  and a selectable fall-through or registered read port.
//  Sits between peripherals (UART/SPI) and the bus or core as the standard buffering stage.
// PARAMETERS
//  WIDTH  8       data width, >= 1
//  DEPTH  16      entry count, any integer >= 2
//  MODE   "fwft"  "fwft": dout shows the head entry combinationally; "reg": dout registered on read
//  LB     derived localparam $clog2(DEPTH+1); width of level and threshold ports
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous reset, active-high
//  clr           in   1      synchronous flush
//  din           in   WIDTH  write data
//  w             in   1      write request
//  r             in   1      read request
//  dout          out  WIDTH  read data
//  dvld          out  1      "fwft": equals !empty; "reg": 1-cycle pulse, dout updated by an accepted read
//  level         out  LB     stored entry count, 0..DEPTH
//  af_th         in   LB     almost_full threshold
//  ae_th         in   LB     almost_empty threshold
//  full          out  1      level == DEPTH
//  empty         out  1      level == 0
//  almost_full   out  1      level >= af_th
//  almost_empty  out  1      level <= ae_th
//  ovf           out  1      sticky: a write was dropped
//  udf           out  1      sticky: a read was dropped
//  err_clr       in   1      synchronous clear of ovf and udf
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous, active-high (rst).
//  - Reset values:
//    - wptr, rptr, level = 0; empty = 1; full = 0.
//    - almost_empty = 1 if ae_th >= 0, so always 1; almost_full = (af_th == 0).
//    - ovf = udf = 0; dvld = 0; dout = 0 in "reg" mode.
//    - Array contents are not reset.
//  - Flags are combinational compares of the registered level only. No path from w/r to flags.
//  - Pointers run 0..DEPTH-1 and wrap explicitly: ptr == DEPTH-1 -> 0. No modulo-2^n arithmetic.
//  - Accepted write: array[wptr] <= din; wptr advances.
//  - Accepted read: rptr advances.
//  - level += accepted write - accepted read, in the same cycle.
//  - Priority per cycle: rst > clr > w/r.
//    - clr: wptr <= rptr, level <= 0, dvld <= 0; w/r in that cycle are ignored.
//    - clr leaves ovf/udf unchanged.
//  - err_clr is independent of clr. When err_clr and a new error occur in the same cycle, the flag stays 1.
//  - Boundary cases for {w, r}:
//    - w, not full: write accepted.
//    - w, full, !r: write dropped; ovf <= 1.
//    - w, full, r: read and write both accepted; level stays DEPTH; no ovf.
//    - r, not empty: read accepted.
//    - r, empty, !w: read dropped; udf <= 1.
//    - r, empty, w: write accepted, read dropped, udf <= 1. No same-cycle bypass.
//  - "fwft" mode: dout = array[rptr] combinationally. Zero-latency; valid whenever !empty.
//  - "reg" mode: on an accepted read, dout <= array[rptr] and dvld <= 1 next cycle.
//    - Otherwise dvld <= 0 and dout holds its value.
//    - Read latency is 1 cycle.
//  - Threshold ports may change on any cycle; flags follow in the same cycle.
//    - Values > DEPTH are legal: almost_full never asserts, almost_empty always asserts.
//  - Reset mid-operation discards all contents immediately, without waiting for the clock.
// STRUCTURE
//  - Shared header rtl/chip/fifo_defs.vh: mode string constants FIFO_MODE_FWFT and FIFO_MODE_REG.
//    Also the LB width macro, reused by other FIFO variants.
//  - Sub-module fifo_ram: DEPTH x WIDTH storage.
//    - Synchronous write port; asynchronous read port.
//    - No reset; inferable as distributed RAM.
//  - fifo_lvl holds the pointers, level counter, flags and output stage.
// TESTING
//  1. Reset, then fill DEPTH=5 with 1..5 -> level 1..5; full at 5.
//     Then drain -> dout 1..5 in order. Pointers wrap without gaps across 3 fill/drain loops.
//  2. Full (DEPTH=5), w=1 with din=0xAA -> ovf=1, level=5, 0xAA never read.
//     Then err_clr -> ovf=0.
//  3. Full, w=r=1 for 10 cycles -> level stays 5, no ovf, data order preserved.
//     Empty, w=r=1 -> level=1, udf=1.
//  4. af_th=3, ae_th=1: step level 0->5->0 -> almost_full high iff level>=3, almost_empty high iff level<=1.
//     Change af_th to 6 at level 5 -> almost_full drops in the same cycle.
//  5. MODE="reg": push 0x11, 0x22; r pulses -> dvld and dout=0x11 one cycle later, then 0x22.
//     dvld=0 on non-read cycles.
//  6. With 3 entries, w=1 and clr=1 together -> level=0, empty=1, no write stored.
//     Assert rst mid-burst -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/fifo_lvl_pkg.sv
// fifo_lvl_pkg: shared mode constants and level-width helper for the FIFO family
package fifo_lvl_pkg;
  localparam string FIFO_MODE_FWFT = "fwft";
  localparam string FIFO_MODE_REG = "reg";
  function automatic int fifo_lb(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [AW-1:0]    i_ra,
  output logic [WIDTH-1:0] o_rd
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  // write port; contents are deliberately left unreset so this maps to distributed RAM
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_wa] <= i_wd;
  assign o_rd = r_mem[i_ra];
endmodule

// File: rtl/fifo_lvl.sv
// fifo_lvl: single-clock FIFO with any depth, live level, thresholds, sticky errors, fwft/reg read port
module fifo_lvl
  import fifo_lvl_pkg::*;
#(
  parameter int    WIDTH = 8,
  parameter int    DEPTH = 16,
  parameter string MODE  = FIFO_MODE_FWFT,
  localparam int   LB    = fifo_lb(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_w,
  input  logic             i_r,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_dvld,
  output logic [LB-1:0]    o_level,
  input  logic [LB-1:0]    i_af_th,
  input  logic [LB-1:0]    i_ae_th,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic             o_ovf,
  output logic             o_udf,
  input  logic             i_err_clr
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]    r_wptr, r_rptr, w_wptr_nx, w_rptr_nx;
  logic [LB-1:0]    r_level;
  logic             r_ovf, r_udf, w_wr, w_rd;
  logic [WIDTH-1:0] w_head;
  assign o_level        = r_level;
  assign o_full         = r_level == LB'(DEPTH);
  assign o_empty        = r_level == '0;
  assign o_almost_full  = r_level >= i_af_th;
  assign o_almost_empty = r_level <= i_ae_th;
  assign o_ovf          = r_ovf;
  assign o_udf          = r_udf;
  // a write into a full FIFO is still accepted when a read frees the slot in the same cycle
  assign w_wr      = i_w && !i_clr && (!o_full || i_r);
  assign w_rd      = i_r && !i_clr && !o_empty;
  assign w_wptr_nx = (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nx = (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
  // pointers wrap explicitly at DEPTH-1 so non-power-of-two depths need no modulo logic
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_clr) begin
      r_wptr  <= r_rptr;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= w_wptr_nx;
      if (w_rd) r_rptr <= w_rptr_nx;
      r_level <= r_level + LB'(w_wr) - LB'(w_rd);
    end
  // sticky error flags; a new error wins over err_clr, and clr neither sets nor clears them
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !i_err_clr) || (i_w && !i_clr && o_full && !i_r);
      r_udf <= (r_udf && !i_err_clr) || (i_r && !i_clr && o_empty);
    end
  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .i_clk (i_clk),
    .i_we  (w_wr),
    .i_wa  (r_wptr),
    .i_wd  (i_din),
    .i_ra  (r_rptr),
    .o_rd  (w_head)
  );
  if (MODE == FIFO_MODE_REG) begin : g_reg
    logic [WIDTH-1:0] r_dout;
    logic             r_dvld;
    // registered port: capture the head on each accepted read, hold it otherwise
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
        r_dout <= '0;
        r_dvld <= 1'b0;
      end else begin
        r_dvld <= w_rd;
        if (w_rd) r_dout <= w_head;
      end
    assign o_dout = r_dout;
    assign o_dvld = r_dvld;
  end else begin : g_fwft
    assign o_dout = w_head;
    assign o_dvld = !o_empty;
  end
endmodule

// File: tb/tb_fifo_lvl.sv
// tb_fifo_lvl: fwft and reg instances of fifo_lvl (DEPTH=5) driven in lockstep against a queue model
module tb_fifo_lvl;
  localparam int D = 5;
  logic clk = 1'b0;
  logic rst, clr, wr, rd, err_clr;
  logic [7:0] din;
  logic [2:0] af_th, ae_th;
  logic [7:0] f_dout, s_dout;
  logic [2:0] f_lvl, s_lvl;
  logic f_dvld, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic s_dvld, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  int vectors = 0, miscompares = 0;
  int q[$];
  bit m_ovf, m_udf, m_dvld;
  logic [7:0] m_dout;
  always #5 clk = ~clk;
  fifo_lvl #(.WIDTH(8), .DEPTH(D), .MODE("fwft")) u_f (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_din(din), .i_w(wr), .i_r(rd),
    .o_dout(f_dout), .o_dvld(f_dvld), .o_level(f_lvl), .i_af_th(af_th), .i_ae_th(ae_th),
    .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_af), .o_almost_empty(f_ae),
    .o_ovf(f_ovf), .o_udf(f_udf), .i_err_clr(err_clr));
  fifo_lvl #(.WIDTH(8), .DEPTH(D), .MODE("reg")) u_r (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_din(din), .i_w(wr), .i_r(rd),
    .o_dout(s_dout), .o_dvld(s_dvld), .o_level(s_lvl), .i_af_th(af_th), .i_ae_th(ae_th),
    .o_full(s_full), .o_empty(s_empty), .o_almost_full(s_af), .o_almost_empty(s_ae),
    .o_ovf(s_ovf), .o_udf(s_udf), .i_err_clr(err_clr));
  wire [35:0] obs = {f_lvl, f_full, f_empty, f_af, f_ae, f_ovf, f_udf,
                     s_lvl, s_full, s_empty, s_af, s_ae, s_ovf, s_udf,
                     f_dvld, s_dvld, s_dout, f_empty ? 8'h00 : f_dout};
  function automatic logic [35:0] expv();
    logic [8:0] st;
    logic [7:0] h;
    int n;
    n = q.size();
    st = {3'(n), n == D, n == 0, n >= int'(af_th), n <= int'(ae_th), m_ovf, m_udf};
    h = (n != 0) ? 8'(q[0]) : 8'h00;
    return {st, st, n != 0, m_dvld, m_dout, h};
  endfunction
  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_dvld = 0; m_dout = 8'h00;
  endtask
  task automatic step(input logic iw, input logic ir, input logic [7:0] id,
                      input logic ic = 1'b0, input logic iec = 1'b0);
    bit full, emp, rok, wok, oe, ue;
    wr = iw; rd = ir; din = id; clr = ic; err_clr = iec;
    @(posedge clk);
    full = q.size() == D; emp = q.size() == 0; oe = 0; ue = 0;
    if (ic) begin
      q.delete();
      m_dvld = 0;
    end else begin
      rok = ir && !emp;
      wok = iw && (!full || ir);
      oe = iw && full && !ir;
      ue = ir && emp;
      m_dvld = rok;
      if (rok) m_dout = 8'(q.pop_front());
      if (wok) q.push_back(int'(id));
    end
    m_ovf = (m_ovf && !iec) || oe;
    m_udf = (m_udf && !iec) || ue;
    @(negedge clk);
    wr = 0; rd = 0; clr = 0; err_clr = 0;
  endtask
  task automatic test_reset();
    rst = 1; clr = 0; wr = 0; rd = 0; err_clr = 0; din = 0; af_th = 0; ae_th = 0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL reset got %h want %h", obs, expv()); end
    af_th = 4; #1;
    vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL reset_af got %h want %h", obs, expv()); end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_fill_drain();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < D; i++) begin
        step(1, 0, 8'(l * 16 + i + 1));
        vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL fill l%0d i%0d got %h want %h", l, i, obs, expv()); end
      end
      for (int i = 0; i < D; i++) begin
        step(0, 1, 8'h00);
        vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL drain l%0d i%0d got %h want %h", l, i, obs, expv()); end
        vectors++; if (s_dout !== 8'(l * 16 + i + 1)) begin miscompares++; $display("FAIL drain_order got %h want %h", s_dout, 8'(l * 16 + i + 1)); end
      end
    end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < D; i++) step(1, 0, 8'(8'h30 + i));
    step(1, 0, 8'hAA);
    vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL ovf_set got %h want %h", obs, expv()); end
    step(0, 0, 8'h00, 0, 1);
    vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL ovf_clr got %h want %h", obs, expv()); end
    for (int i = 0; i < D; i++) begin
      step(0, 1, 8'h00);
      vectors++; if (obs !== expv() || s_dout === 8'hAA) begin miscompares++; $display("FAIL ovf_drain got %h want %h", obs, expv()); end
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < D; i++) step(1, 0, 8'($urandom));
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'($urandom));
      vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL b2b_full %0d got %h want %h", i, obs, expv()); end
    end
    for (int i = 0; i < D; i++) begin
      step(0, 1, 8'h00);
      vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL b2b_drain %0d got %h want %h", i, obs, expv()); end
    end
    step(1, 1, 8'h5C);
    vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL b2b_empty got %h want %h", obs, expv()); end
    step(0, 1, 8'h00, 0, 1);
    vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL b2b_udfclr got %h want %h", obs, expv()); end
  endtask
  task automatic test_thresholds();
    af_th = 3; ae_th = 1;
    for (int i = 0; i < D; i++) begin
      step(1, 0, 8'(8'h40 + i));
      vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL th_up %0d got %h want %h", i, obs, expv()); end
    end
    af_th = 6; #1;
    vectors++; if (f_af !== 1'b0 || obs !== expv()) begin miscompares++; $display("FAIL th_af6 got %h want %h", obs, expv()); end
    af_th = 3;
    for (int i = 0; i < D; i++) begin
      step(0, 1, 8'h00);
      vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL th_down %0d got %h want %h", i, obs, expv()); end
    end
  endtask
  task automatic test_reg_mode();
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(0, 1, 8'h00);
    vectors++; if ({s_dvld, s_dout} !== 9'h111 || obs !== expv()) begin miscompares++; $display("FAIL reg_rd1 got %h want %h", obs, expv()); end
    step(0, 0, 8'h00);
    vectors++; if (s_dvld !== 1'b0 || obs !== expv()) begin miscompares++; $display("FAIL reg_idle got %h want %h", obs, expv()); end
    step(0, 1, 8'h00);
    vectors++; if ({s_dvld, s_dout} !== 9'h122 || obs !== expv()) begin miscompares++; $display("FAIL reg_rd2 got %h want %h", obs, expv()); end
    step(0, 0, 8'h00);
    vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL reg_idle2 got %h want %h", obs, expv()); end
  endtask
  task automatic test_clear();
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h50 + i));
    step(1, 0, 8'h77, 1);
    vectors++; if (f_lvl !== 3'd0 || obs !== expv()) begin miscompares++; $display("FAIL clr got %h want %h", obs, expv()); end
    step(1, 0, 8'h12);
    step(0, 1, 8'h00);
    vectors++; if (s_dout !== 8'h12 || obs !== expv()) begin miscompares++; $display("FAIL clr_after got %h want %h", obs, expv()); end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1, i[0], 8'($urandom));
    step(0, 1, 8'h00);
    wr = 1; din = 8'hE1; #2;
    rst = 1; #1;
    model_reset();
    vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL rst_mid got %h want %h", obs, expv()); end
    wr = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL rst_release got %h want %h", obs, expv()); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) begin af_th = 3'($urandom_range(0, 7)); ae_th = 3'($urandom_range(0, 7)); end
      step(($urandom % 100) < 55, ($urandom % 100) < 45, 8'($urandom),
           ($urandom % 40) == 0, ($urandom % 20) == 0);
      vectors++; if (obs !== expv()) begin miscompares++; $display("FAIL rand %0d got %h want %h", i, obs, expv()); end
    end
  endtask
  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_thresholds();
    test_reg_mode();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
